// File: rtl/sobel_pkg.sv
// Shared types for the Sobel window generator: pixel word, 3x3 window and
// the frame-tracking state encoding.
package sobel_pkg;

   localparam int PIX_W = 16;

   typedef logic [PIX_W-1:0] pixel_t;

   // Word k = 3*row + col; row 0 is the oldest line, col 0 the oldest column
   typedef pixel_t [8:0] window_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } win_state_t;

endpackage

// File: rtl/sobel_window_gen_rgb565_if.sv
// Pixel-stream input and window output bundle of the Sobel window generator.
// The slave modport is the generator's view, the master modport the view of
// whoever feeds pixels and consumes windows.
interface sobel_window_gen_rgb565_if #(
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240
);
   import sobel_pkg::*;

   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);

   pixel_t          pix_in;
   logic            pix_valid;
   logic            pix_sof;
   window_t         win_data;
   logic            win_valid;
   logic [XW-1:0]   win_x;
   logic [YW-1:0]   win_y;
   logic            frame_done;

   modport master (
      output pix_in, pix_valid, pix_sof,
      input  win_data, win_valid, win_x, win_y, frame_done
   );

   modport slave (
      input  pix_in, pix_valid, pix_sof,
      output win_data, win_valid, win_x, win_y, frame_done
   );

endinterface

// File: rtl/sobel_window_gen_rgb565_line_buffer.sv
// One image row of RGB565 pixels. A single address serves both ports: the
// read is combinational and a write lands on the clock edge, so reading the
// address being written in the same cycle yields the previous row's pixel.
module line_buffer_rgb565
   import sobel_pkg::*;
#(
   parameter  int DEPTH = 320,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  pixel_t        wdata,
   output pixel_t        rdata
);

   pixel_t mem [DEPTH];

   assign rdata = mem[addr];

   // Row storage is never cleared; the window logic never exposes stale data
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/sobel_window_gen_rgb565.sv
// Turns a raster RGB565 pixel stream into 3x3 neighbourhood windows for the
// Sobel filter. Two line buffers hold the previous two rows; a 3x3 register
// window shifts left one column per accepted pixel. A window is flagged valid
// only once the accepted pixel closes a full neighbourhood (x>=2, y>=2).
module sobel_window_gen_rgb565
   import sobel_pkg::*;
#(
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240
) (
   input  logic                       clk,
   input  logic                       reset,
   sobel_window_gen_rgb565_if.slave   bus
);

   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);

   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
   localparam logic [XW-1:0] X_ONE  = XW'(1);
   localparam logic [YW-1:0] Y_ONE  = YW'(1);
   localparam logic [XW-1:0] X_TWO  = XW'(2);
   localparam logic [YW-1:0] Y_TWO  = YW'(2);

   win_state_t      state_q, state_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   window_t         window_q, window_d;
   logic            win_valid_q, win_valid_d;
   logic [XW-1:0]   win_x_q, win_x_d;
   logic [YW-1:0]   win_y_q, win_y_d;
   logic            frame_done_q, frame_done_d;

   logic            accept;
   logic            last_pix;
   logic [XW-1:0]   cur_x;
   logic [YW-1:0]   cur_y;
   pixel_t          lb0_rd;
   pixel_t          lb1_rd;

   // lb0 holds row y-1, lb1 holds row y-2; both shift down on every accepted pixel
   line_buffer_rgb565 #(.DEPTH(IMG_WIDTH)) lb0 (
      .clk   (clk),
      .we    (accept),
      .addr  (cur_x),
      .wdata (bus.pix_in),
      .rdata (lb0_rd)
   );

   line_buffer_rgb565 #(.DEPTH(IMG_WIDTH)) lb1 (
      .clk   (clk),
      .we    (accept),
      .addr  (cur_x),
      .wdata (lb0_rd),
      .rdata (lb1_rd)
   );

   // Accept/position decode, window shift, counters and output flags.
   // A start-of-frame pixel restarts at (0,0) even in the middle of a frame,
   // abandoning the old frame without a frame_done.
   always_comb begin
      accept       = bus.pix_valid && (bus.pix_sof || (state_q == ACTIVE));
      cur_x        = bus.pix_sof ? '0 : x_q;
      cur_y        = bus.pix_sof ? '0 : y_q;
      last_pix     = (cur_x == X_LAST) && (cur_y == Y_LAST);

      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      window_d     = window_q;
      win_valid_d  = 1'b0;
      win_x_d      = win_x_q;
      win_y_d      = win_y_q;
      frame_done_d = 1'b0;

      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            window_d[3*r]     = window_q[3*r + 1];
            window_d[3*r + 1] = window_q[3*r + 2];
         end
         window_d[2]  = lb1_rd;
         window_d[5]  = lb0_rd;
         window_d[8]  = bus.pix_in;

         win_valid_d  = (cur_x >= X_TWO) && (cur_y >= Y_TWO);
         win_x_d      = cur_x - X_ONE;
         win_y_d      = cur_y - Y_ONE;
         frame_done_d = last_pix;

         if (last_pix) begin
            x_d     = '0;
            y_d     = '0;
            state_d = IDLE;
         end else if (cur_x == X_LAST) begin
            x_d     = '0;
            y_d     = cur_y + Y_ONE;
            state_d = ACTIVE;
         end else begin
            x_d     = cur_x + X_ONE;
            y_d     = cur_y;
            state_d = ACTIVE;
         end
      end
   end

   // State, window and output registers; reset returns to waiting for a frame start
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         window_q     <= '0;
         win_valid_q  <= 1'b0;
         win_x_q      <= '0;
         win_y_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         window_q     <= window_d;
         win_valid_q  <= win_valid_d;
         win_x_q      <= win_x_d;
         win_y_q      <= win_y_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.win_data   = window_q;
   assign bus.win_valid  = win_valid_q;
   assign bus.win_x      = win_x_q;
   assign bus.win_y      = win_y_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen_rgb565.sv
// Scoreboard bench for the Sobel window generator on a 4x4 image. The
// stimulus side records every pixel it sends in a reference image and queues
// the window each neighbourhood-closing pixel must produce; a negedge monitor
// pops and compares whenever the generator flags a window or a frame end.
module tb_sobel_window_gen_rgb565;
   import sobel_pkg::*;

   localparam int W = 4;
   localparam int H = 4;

   typedef struct {
      logic [143:0] data;
      int           x;
      int           y;
   } exp_t;

   logic   clk = 1'b0;
   logic   reset;

   exp_t   sb [$];
   int     checks     = 0;
   int     errors     = 0;
   int     fd_expect  = 0;
   int     win_seen   = 0;
   pixel_t img [H][W];

   always #5 clk = ~clk;

   sobel_window_gen_rgb565_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

   sobel_window_gen_rgb565 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Compare one value and report any difference
   task automatic checkOutput(input string name, input logic [143:0] act, input logic [143:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Present one input cycle; returns just after the edge that consumed it
   task automatic applyStimulus(input logic v, input pixel_t p, input logic s);
      bus.pix_valid = v;
      bus.pix_in    = p;
      bus.pix_sof   = s;
      @(posedge clk);
      #1;
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
   endtask

   // Reference window centred on (cx,cy), built straight from the image
   function automatic logic [143:0] model_win(input int cx, input int cy);
      logic [143:0] w;
      w = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[16*(3*r + c) +: 16] = img[cy - 1 + r][cx - 1 + c];
      return w;
   endfunction

   task automatic send_pixel(input int x, input int y, input logic sof, input pixel_t p, input logic gaps);
      if (gaps) repeat ($urandom_range(1, 5)) applyStimulus(1'b0, 16'h0000, 1'b0);
      img[y][x] = p;
      if (x >= 2 && y >= 2) sb.push_back('{data: model_win(x - 1, y - 1), x: x - 1, y: y - 1});
      if (x == W - 1 && y == H - 1) fd_expect++;
      applyStimulus(1'b1, p, sof);
      if (x == W - 1 && y == H - 1) checkOutput("frame_done after last pixel", 144'(bus.frame_done), 144'd1);
   endtask

   // mode 0: solid red, 1: ramp 4*y+x, 2: top half red / bottom half black
   task automatic send_frame(input int mode, input logic gaps);
      pixel_t p;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            case (mode)
               0:       p = 16'hF800;
               1:       p = pixel_t'(4*y + x);
               default: p = (y < 2) ? 16'hF800 : 16'h0000;
            endcase
            send_pixel(x, y, (x == 0 && y == 0), p, gaps);
         end
      end
   endtask

   // Monitor: every flagged window must match the head of the scoreboard,
   // and every frame_done pulse must have been announced by the stimulus
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (bus.win_valid) begin
            win_seen++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected window: got centre (%0d,%0d), required none", bus.win_x, bus.win_y);
            end else begin
               e = sb.pop_front();
               checkOutput("window data", bus.win_data, e.data);
               checkOutput("window x", 144'(bus.win_x), 144'(e.x));
               checkOutput("window y", 144'(bus.win_y), 144'(e.y));
            end
         end
         if (bus.frame_done) begin
            checks++;
            if (fd_expect == 0) begin
               errors++;
               $display("[TB] FAIL unexpected frame_done: got 1, required 0");
            end else begin
               fd_expect--;
            end
         end
      end
   end

   initial begin
      reset         = 1'b1;
      bus.pix_valid = 1'b0;
      bus.pix_in    = 16'h0000;
      bus.pix_sof   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      checkOutput("reset win_data", bus.win_data, 144'd0);
      checkOutput("reset flags", 144'({bus.win_valid, bus.frame_done, bus.win_x, bus.win_y}), 144'd0);

      // Partial ramp frame up to the first window, then an asynchronous reset
      for (int i = 0; i < 11; i++) send_pixel(i % 4, i / 4, (i == 0), pixel_t'(i), 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async reset win_data", bus.win_data, 144'd0);
      checkOutput("async reset win_x", 144'(bus.win_x), 144'd0);
      checkOutput("async reset win_y", 144'(bus.win_y), 144'd0);
      checkOutput("async reset flags", 144'({bus.win_valid, bus.frame_done}), 144'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Without a start of frame nothing is accepted
      repeat (8) applyStimulus(1'b1, 16'h1234, 1'b0);
      checkOutput("no-sof pixels dropped", bus.win_data, 144'd0);

      send_frame(0, 1'b0);
      repeat (2) applyStimulus(1'b0, 16'h0000, 1'b0);
      send_frame(1, 1'b0);
      send_frame(2, 1'b0);
      send_frame(1, 1'b1);

      // Abort after six pixels with a fresh start of frame
      for (int i = 0; i < 6; i++) send_pixel(i % 4, i / 4, (i == 0), pixel_t'(i), 1'b0);
      send_frame(1, 1'b0);
      repeat (3) applyStimulus(1'b1, 16'hABCD, 1'b0);
      repeat (4) applyStimulus(1'b0, 16'h0000, 1'b0);

      checkOutput("windows still outstanding", 144'(sb.size()), 144'd0);
      checkOutput("frame_done pulses missing", 144'(fd_expect), 144'd0);
      checkOutput("total windows", 144'(win_seen), 144'd21);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
